// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: FSM state encoding and RV32 load/store funct3 codes.
// Consumed by load_store_unit and lsu_align via import riscv_pkg::*.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed memory bus between the LSU (master) and memory (slave).
// Request held until mem_gnt; mem_rvalid returns read data or write ack.
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: store lane/byte-enable generation, op legality, load extraction.
// LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses illegal.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        illegal,
    output logic [31:0] ld_data
);

    logic        misalign;
    logic        bad_f3;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (st_funct3[1:0] == 2'b01 && st_off[0]) ||
                      (st_funct3[1:0] == 2'b10 && st_off != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign bad_f3  = st_we ? st_funct3[2]
                           : (st_funct3 inside {3'b011, 3'b110, 3'b111});
    assign illegal = bad_f3 || misalign;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        if (st_we) begin
            unique case (st_funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << st_off;
                    wdata = {4{st_data[7:0]}};
                end
                2'b01: begin
                    be    = st_off[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{st_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (ld_off)
            2'b00: ld_byte = ld_word[7:0];
            2'b01: ld_byte = ld_word[15:8];
            2'b10: ld_byte = ld_word[23:16];
            2'b11: ld_byte = ld_word[31:24];
        endcase
    end

    assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        unique case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-op-at-a-time RV32 LSU FSM with bus timeout.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               stall,
    output logic               done,
    output logic               err,
    output logic [31:0]        rdata,
    load_store_unit_if.master  bus
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1) + 1;

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic        tmo;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic        mreq, mwe;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mbe;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_ldata;
    logic        a_illegal;

    lsu_align u_align (
        .st_we     (req_we),
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .ld_funct3 (ld_f3),
        .ld_off    (ld_off),
        .ld_word   (bus.mem_rdata),
        .be        (a_be),
        .wdata     (a_wdata),
        .illegal   (a_illegal),
        .ld_data   (a_ldata)
    );

    assign cnt_inc = cnt + 1'b1;
    assign tmo     = cnt_inc >= CW'(TIMEOUT_CYC);

    // Stall follows req_valid in IDLE so the core freezes the same cycle.
    assign stall = reset &&
                   ((state == IDLE) ? req_valid
                                    : (state == REQ || state == WAIT));

    assign bus.mem_req   = mreq;
    assign bus.mem_we    = mwe;
    assign bus.mem_addr  = maddr;
    assign bus.mem_be    = mbe;
    assign bus.mem_wdata = mwdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ld_f3  <= 3'b0;
            ld_off <= 2'b0;
            mreq   <= 1'b0;
            mwe    <= 1'b0;
            maddr  <= 32'h0;
            mbe    <= 4'h0;
            mwdata <= 32'h0;
            done   <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        ld_f3  <= req_funct3;
                        ld_off <= req_addr[1:0];
                        cnt    <= '0;
                        if (a_illegal) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= 32'h0;
                        end else begin
                            state  <= REQ;
                            mreq   <= 1'b1;
                            mwe    <= req_we;
                            maddr  <= {req_addr[31:2], 2'b00};
                            mbe    <= a_be;
                            mwdata <= a_wdata;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt_inc;
                    if (bus.mem_gnt || tmo) begin
                        mreq   <= 1'b0;
                        mwe    <= 1'b0;
                        maddr  <= 32'h0;
                        mbe    <= 4'h0;
                        mwdata <= 32'h0;
                    end
                    if (bus.mem_gnt) begin
                        state <= WAIT;
                    end else if (tmo) begin
                        state <= ERR;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (bus.mem_rvalid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        rdata <= a_ldata;
                    end else if (tmo) begin
                        state <= ERR;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-word expectation.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int total  = 0;
    int passed = 0;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string nm,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, nm, obs, exp_v);
    endtask

    task automatic chk1(input string tag, input string nm,
                        input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s.%s observed=%b expected=%b", tag, nm, obs, exp_v);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // Minimum-latency op: gnt in first REQ cycle, rvalid the next.
    task automatic op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic [31:0] ea,
                      input logic [3:0] ebe, input logic [31:0] ewd,
                      input logic [31:0] erd);
        issue(we, f3, a, wd);
        @(negedge clk);
        chk1(tag, "stall_c0", stall, 1'b1);
        @(posedge clk); #1;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        chk1(tag, "mem_req", bus.mem_req, 1'b1);
        chk1(tag, "mem_we", bus.mem_we, we);
        chk(tag, "mem_addr", bus.mem_addr, ea);
        chk(tag, "mem_be", {28'h0, bus.mem_be}, {28'h0, ebe});
        if (we) chk(tag, "mem_wdata", bus.mem_wdata, ewd);
        chk1(tag, "stall_c1", stall, 1'b1);
        @(posedge clk); #1;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        @(negedge clk);
        chk1(tag, "stall_c2", stall, 1'b1);
        chk1(tag, "mem_req_wait", bus.mem_req, 1'b0);
        chk1(tag, "done_c2", done, 1'b0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        req_valid      = 1'b0;
        @(negedge clk);
        chk1(tag, "done", done, 1'b1);
        chk1(tag, "err", err, 1'b0);
        chk1(tag, "stall_c3", stall, 1'b0);
        if (!we) chk(tag, "rdata", rdata, erd);
        @(posedge clk); #1;
    endtask

    // Illegal op: err+done the cycle after req_valid, no bus request.
    task automatic bad_op(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a);
        issue(we, f3, a, 32'h0);
        @(negedge clk);
        chk1(tag, "mem_req_c0", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk1(tag, "done", done, 1'b1);
        chk1(tag, "err", err, 1'b1);
        chk1(tag, "mem_req_c1", bus.mem_req, 1'b0);
        chk(tag, "rdata", rdata, 32'h0);
        chk1(tag, "stall", stall, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int hi;
        int seen;
        reset          = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_funct3     = 3'b0;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst", "stall", stall, 1'b0);
        chk1("rst", "done", done, 1'b0);
        chk1("rst", "err", err, 1'b0);
        chk("rst", "rdata", rdata, 32'h0);
        chk1("rst", "mem_req", bus.mem_req, 1'b0);
        chk1("rst", "mem_we", bus.mem_we, 1'b0);
        chk("rst", "mem_addr", bus.mem_addr, 32'h0);
        chk("rst", "mem_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst", "mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        op("sw", 1'b1, 3'b010, 32'h64, 32'h19, 32'h0,
           32'h64, 4'b1111, 32'h19, 32'h0);
        @(negedge clk);
        chk1("sw", "done_after", done, 1'b0);
        @(posedge clk); #1;

        op("lb", 1'b0, 3'b000, 32'h63, 32'h0, 32'h80FF1234,
           32'h60, 4'b1111, 32'h0, 32'hFFFFFF80);
        op("lbu", 1'b0, 3'b100, 32'h63, 32'h0, 32'h80FF1234,
           32'h60, 4'b1111, 32'h0, 32'h00000080);
        op("lhu", 1'b0, 3'b101, 32'h62, 32'h0, 32'h80FF1234,
           32'h60, 4'b1111, 32'h0, 32'h000080FF);
        op("lh", 1'b0, 3'b001, 32'h62, 32'h0, 32'h80FF1234,
           32'h60, 4'b1111, 32'h0, 32'hFFFF80FF);
        op("lw", 1'b0, 3'b010, 32'h64, 32'h0, 32'h12345678,
           32'h64, 4'b1111, 32'h0, 32'h12345678);
        op("sh", 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0,
           32'h20, 4'b1100, 32'hABCDABCD, 32'h0);
        op("sh_lo", 1'b1, 3'b001, 32'h30, 32'h12345678, 32'h0,
           32'h30, 4'b0011, 32'h56785678, 32'h0);
        op("sb", 1'b1, 3'b000, 32'h41, 32'h0000005A, 32'h0,
           32'h40, 4'b0010, 32'h5A5A5A5A, 32'h0);

        bad_op("ld_f3_011", 1'b0, 3'b011, 32'h10);
        bad_op("ld_f3_110", 1'b0, 3'b110, 32'h10);
        bad_op("st_f3_100", 1'b1, 3'b100, 32'h10);

`ifdef LSU_MISALIGN_TRAP_EN
        bad_op("lw_mis", 1'b0, 3'b010, 32'h66);
        bad_op("sh_mis", 1'b1, 3'b001, 32'h23);
`else
        op("lw_mis", 1'b0, 3'b010, 32'h66, 32'h0, 32'hDEADBEEF,
           32'h64, 4'b1111, 32'h0, 32'hDEADBEEF);
        op("sh_mis", 1'b1, 3'b001, 32'h23, 32'h00001122, 32'h0,
           32'h20, 4'b1100, 32'h11221122, 32'h0);
`endif

        // Timeout with gnt never asserted.
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        @(posedge clk); #1;
        hi   = 0;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.mem_req) hi++;
            if (done) begin
                seen = 1;
                chk1("tmo", "err", err, 1'b1);
                chk("tmo", "rdata", rdata, 32'h0);
                chk1("tmo", "mem_req_err", bus.mem_req, 1'b0);
                break;
            end
        end
        chk1("tmo", "done_seen", seen == 1, 1'b1);
        chk("tmo", "req_cycles", hi, 32'd16);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        op("tmo_next", 1'b0, 3'b100, 32'h101, 32'h0, 32'h0000C300,
           32'h100, 4'b1111, 32'h0, 32'h000000C3);

        // Reset during WAIT; late rvalid must be ignored.
        issue(1'b0, 3'b010, 32'h80, 32'h0);
        @(posedge clk); #1;
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        req_valid   = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        chk1("rstw", "stall", stall, 1'b0);
        chk1("rstw", "done", done, 1'b0);
        chk1("rstw", "mem_req", bus.mem_req, 1'b0);
        chk("rstw", "mem_addr", bus.mem_addr, 32'h0);
        chk("rstw", "rdata", rdata, 32'h0);
        @(posedge clk); #1;
        reset          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        chk1("rstw", "done_rv", done, 1'b0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk1("rstw", "done_late", done, 1'b0);
        chk1("rstw", "stall_late", stall, 1'b0);
        chk("rstw", "rdata_late", rdata, 32'h0);
        @(posedge clk); #1;
        op("rst_next", 1'b0, 3'b000, 32'h82, 32'h0, 32'h007F0000,
           32'h80, 4'b1111, 32'h0, 32'h0000007F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: max cycles from entering REQ to mem_rvalid before a bus error.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  core presents a memory op; held, with all req_* stable, while stall=1.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_funct3  in  3  instruction funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw).
REQ-007 req_addr  in  32  byte address (ALU result).
REQ-008 req_wdata  in  32  store data (rs2).
REQ-009 stall  out  1  freeze PC/regfile write.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle error pulse, coincident with done.
REQ-012 rdata  out  32  formatted load result, valid while done=1.
REQ-013 mem_req, mem_we  out  1 each  bus request, write flag.
REQ-014 mem_addr  out  32  word address, bits[1:0]=0.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_gnt, mem_rvalid  in  1 each  request accepted; read data / write ack.
REQ-018 mem_rdata  in  32  read word.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE, ERR; every op latched on IDLE exit.
REQ-020 IDLE: req_valid and legal op -> REQ; illegal op -> ERR; stall=req_valid (combinational).
REQ-021 REQ: mem_req=1 with latched addr/be/wdata/we; mem_gnt -> WAIT; stall=1.
REQ-022 WAIT: mem_req=0; mem_rvalid -> DONE, capturing formatted rdata; stall=1; mem_rvalid is ignored in every other state.
REQ-023 DONE: done=1, stall=0 for one cycle -> IDLE.
REQ-024 ERR: done=1, err=1, rdata=0, stall=0 for one cycle, no bus request -> IDLE.
REQ-025 Minimum latency (gnt in first REQ cycle, rvalid the next cycle): done 3 cycles after req_valid rises; stores also wait for mem_rvalid.
REQ-026 Timeout counter clears on entering REQ and increments each REQ/WAIT cycle; reaching TIMEOUT_CYC -> ERR, mem_req dropped that cycle.
REQ-027 Illegal op: load funct3 011/110/111, or store funct3 bit2=1.
REQ-028 Store lanes: sb be=1<<addr[1:0], byte replicated x4; sh be=0011/1100 by addr[1], half replicated x2; sw be=1111.
REQ-029 Loads: be=1111; lb/lh sign-extend, lbu/lhu zero-extend the selected lane; lw passes the word.

Reset
REQ-030 While reset=0: state=IDLE, counter=0, and stall, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata and rdata all 0.
REQ-031 Reset mid-operation abandons the op immediately; late mem_gnt/mem_rvalid are ignored.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is illegal -> ERR.
REQ-033 Macro undefined: offending low address bits are ignored (half uses addr[1], word uses the aligned word); no error is raised.

Structure
REQ-034 Package riscv_pkg holds lsu_state_t enum and funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-035 Combinational sub-module lsu_align generates mem_be/mem_wdata and load extraction; FSM and counter stay in load_store_unit.

Verification
REQ-036 sw addr=0x64 wdata=0x19, gnt next cycle, rvalid following -> mem_addr=0x64, be=1111, mem_wdata=0x19; stall=1 for 3 cycles; done at cycle 3.
REQ-037 lb addr=0x63, mem_rdata=0x80FF1234 -> rdata=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x62 -> 0x000080FF.
REQ-038 sh addr=0x22 wdata=0x0000ABCD -> mem_addr=0x20, be=1100, mem_wdata=0xABCDABCD.
REQ-039 lw addr=0x66: with macro -> err+done next cycle, mem_req never 1; without macro -> mem_addr=0x64, be=1111, normal done.
REQ-040 TIMEOUT_CYC=16, gnt never asserted -> mem_req high 16 cycles, then err=done=1, rdata=0; next op completes normally.
REQ-041 reset=0 during WAIT, rvalid asserted after release -> all outputs 0, no done pulse, state IDLE.
